// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, ALU ops
// and a generic sign-extension helper.
package proc_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLT   = 4'h5,
    OP_ADDI  = 4'h6,
    OP_LW    = 4'h7,
    OP_SW    = 4'h8,
    OP_BEQ   = 4'h9,
    OP_BNE   = 4'hA,
    OP_JMP   = 4'hB,
    OP_NOP_C = 4'hC,
    OP_NOP_D = 4'hD,
    OP_NOP_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT
  } alu_op_e;

  localparam int EXT_W = 64;

  // Sign-extend the low w bits of v to EXT_W bits; callers size-cast the result.
  function automatic logic [EXT_W-1:0] sext(input logic [EXT_W-1:0] v, input int w);
    logic signed [EXT_W-1:0] t;
    t = $signed(v << (EXT_W - w));
    return $unsigned(t >>> (EXT_W - w));
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: add/sub with signed-overflow detect, logic ops, signed SLT.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  logic signed [DATA_W-1:0] sa, sb, sum, dif;

  always_comb begin
    sa       = $signed(a);
    sb       = $signed(b);
    sum      = sa + sb;
    dif      = sa - sb;
    result   = '0;
    overflow = 1'b0;
    case (alu_op_e'(op))
      ALU_ADD: begin
        result   = $unsigned(sum);
        overflow = (sa[DATA_W-1] == sb[DATA_W-1]) && (sum[DATA_W-1] != sa[DATA_W-1]);
      end
      ALU_SUB: begin
        result   = $unsigned(dif);
        overflow = (sa[DATA_W-1] != sb[DATA_W-1]) && (dif[DATA_W-1] != sa[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, (sa < sb)};
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle core with req/ack instruction and data memory ports.
// Optional RETIRE_TRACE_EN adds a per-instruction retire trace port.
module multicycle_cpu_core
  import proc_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int REG_ADDR_W = 2,
  parameter  int PC_W       = 8,
  parameter  int IMM_W      = 8,
  localparam int INSTR_W    = 4 + 2*REG_ADDR_W + IMM_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               ovf,
  output logic               halted
`ifdef RETIRE_TRACE_EN
  ,
  output logic               retire_valid,
  output logic [PC_W-1:0]    retire_pc,
  output logic [INSTR_W-1:0] retire_instr
`endif
);

  localparam int NREG = 2**REG_ADDR_W;

  state_e                  state, state_nx;
  logic [PC_W-1:0]         pc;
  logic [INSTR_W-1:0]      ir;
  logic [DATA_W-1:0]       regs [NREG];
  logic [DATA_W-1:0]       opa, opb, res;

  opcode_e                 op;
  logic [REG_ADDR_W-1:0]   rs, rt, rd, wb_idx;
  logic [IMM_W-1:0]        imm;
  logic [DATA_W-1:0]       imm_d, alu_b, alu_res;
  logic [PC_W-1:0]         pc_inc, pc_br, jmp_tgt;
  alu_op_e                 alu_op;
  logic                    alu_ovf;

  assign op      = opcode_e'(ir[INSTR_W-1 -: 4]);
  assign rs      = ir[INSTR_W-5 -: REG_ADDR_W];
  assign rt      = ir[INSTR_W-5-REG_ADDR_W -: REG_ADDR_W];
  assign imm     = ir[IMM_W-1:0];
  assign rd      = imm[IMM_W-1 -: REG_ADDR_W];
  assign wb_idx  = (op == OP_ADDI || op == OP_LW) ? rt : rd;

  assign imm_d   = DATA_W'(sext(EXT_W'(imm), IMM_W));
  assign pc_inc  = pc + PC_W'(1);
  assign pc_br   = pc_inc + PC_W'(sext(EXT_W'(imm), IMM_W));
  assign jmp_tgt = PC_W'(imm);

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = opb;
    case (op)
      OP_SUB:               alu_op = ALU_SUB;
      OP_AND:               alu_op = ALU_AND;
      OP_OR:                alu_op = ALU_OR;
      OP_XOR:               alu_op = ALU_XOR;
      OP_SLT:               alu_op = ALU_SLT;
      OP_ADDI, OP_LW, OP_SW: alu_b  = imm_d;
      default: ;
    endcase
  end

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .a        (opa),
    .b        (alu_b),
    .op       (alu_op),
    .result   (alu_res),
    .overflow (alu_ovf)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_FETCH:  if (imem_ack) state_nx = ST_DECODE;
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_LW, OP_SW: state_nx = ST_MEM;
          OP_HALT:      state_nx = ST_HALT;
          OP_BEQ, OP_BNE, OP_JMP, OP_NOP_C, OP_NOP_D, OP_NOP_E: state_nx = ST_FETCH;
          default:      state_nx = ST_WB;
        endcase
      end
      ST_MEM:    if (dmem_ack) state_nx = (op == OP_LW) ? ST_WB : ST_FETCH;
      ST_WB:     state_nx = ST_FETCH;
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_FETCH;
    endcase
  end

  // Requests are gated by rst so an in-flight handshake drops the moment reset asserts.
  assign imem_req   = (state == ST_FETCH) && !rst;
  assign imem_addr  = pc;
  assign dmem_req   = (state == ST_MEM);
  assign dmem_we    = (state == ST_MEM) && (op == OP_SW);
  assign dmem_addr  = res;
  assign dmem_wdata = opb;
  assign halted     = (state == ST_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_FETCH:  if (imem_ack) ir <= imem_rdata;
        ST_DECODE: begin
          opa <= regs[rs];
          opb <= regs[rt];
        end
        ST_EXEC: begin
          res <= alu_res;
          if (alu_ovf && (op == OP_ADD || op == OP_SUB || op == OP_ADDI)) ovf <= 1'b1;
          case (op)
            OP_BEQ:  pc <= (opa == opb) ? pc_br : pc_inc;
            OP_BNE:  pc <= (opa != opb) ? pc_br : pc_inc;
            OP_JMP:  pc <= jmp_tgt;
            OP_NOP_C, OP_NOP_D, OP_NOP_E: pc <= pc_inc;
            default: ;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (op == OP_LW) res <= dmem_rdata;
            else             pc  <= pc_inc;
          end
        end
        ST_WB: begin
          regs[wb_idx] <= res;
          pc           <= pc_inc;
        end
        default: ;
      endcase
    end
  end

`ifdef RETIRE_TRACE_EN
  always_comb begin
    retire_valid = 1'b0;
    if (!rst) begin
      case (state)
        ST_WB:   retire_valid = 1'b1;
        ST_MEM:  retire_valid = dmem_ack && (op == OP_SW);
        ST_EXEC: retire_valid = (op == OP_BEQ || op == OP_BNE || op == OP_JMP || op == OP_HALT ||
                                 op == OP_NOP_C || op == OP_NOP_D || op == OP_NOP_E);
        default: ;
      endcase
    end
    retire_pc    = retire_valid ? pc : '0;
    retire_instr = retire_valid ? ir : '0;
  end
`endif

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Scoreboard bench: an ISA-level model predicts fetch and data transactions,
// a monitor compares them against what the core presents on its memory ports.
module tb_multicycle_cpu_core;

  localparam int DATA_W = 8, REG_ADDR_W = 2, PC_W = 8, IMM_W = 8, INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req, imem_ack;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req, dmem_we, dmem_ack;
  logic [DATA_W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic               ovf, halted;
`ifdef RETIRE_TRACE_EN
  logic               retire_valid;
  logic [PC_W-1:0]    retire_pc;
  logic [INSTR_W-1:0] retire_instr;
  int                 retire_cnt;
`endif

  multicycle_cpu_core #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .PC_W(PC_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .ovf(ovf), .halted(halted)
`ifdef RETIRE_TRACE_EN
    , .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] pc; logic ov; } fetch_t;
  typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } dtxn_t;

  fetch_t      exp_fetch[$];
  dtxn_t       exp_dmem[$];
  logic [15:0] prog [256];
  logic [7:0]  dmem [256];
  logic [7:0]  mm   [256];
  int          idly = 0, ddly = 0, stall_pc = -1;
  int          n_checks = 0, n_pass = 0;
  int          m_steps;
  logic        m_ovf;
  logic [7:0]  m_halt_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, req);
  endtask

  function automatic logic [15:0] ei(input int op, input int rs, input int rt, input int imm);
    return {4'(op), 2'(rs), 2'(rt), 8'(imm)};
  endfunction

  function automatic logic [15:0] er(input int op, input int rs, input int rt, input int rd);
    return ei(op, rs, rt, rd * 64);
  endfunction

  function automatic int sv(input logic [7:0] x);
    return (x >= 8'd128) ? int'(x) - 256 : int'(x);
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
  endtask

  // Instruction-level reference: executes the program from reset state.
  task automatic model_run(input int max_steps);
    logic [7:0] r [4];
    logic [7:0] pc, nxt, a, b, addr;
    logic [15:0] ins;
    int op, rs, rt, rd, simm, s;
    bit done;
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    pc = 8'h00; m_ovf = 1'b0; m_steps = 0; done = 0; m_halt_pc = 8'h00;
    while (!done && m_steps < max_steps) begin
      ins = prog[pc];
      op = int'(ins[15:12]); rs = int'(ins[11:10]); rt = int'(ins[9:8]);
      rd = int'(ins[7:6]); simm = sv(ins[7:0]);
      exp_fetch.push_back('{pc, m_ovf});
      m_steps++;
      a = r[rs]; b = r[rt]; nxt = pc + 8'd1;
      addr = 8'(int'(a) + simm);
      case (op)
        0: begin s = sv(a) + sv(b); if (s > 127 || s < -128) m_ovf = 1'b1; r[rd] = 8'(s); end
        1: begin s = sv(a) - sv(b); if (s > 127 || s < -128) m_ovf = 1'b1; r[rd] = 8'(s); end
        2: r[rd] = a & b;
        3: r[rd] = a | b;
        4: r[rd] = a ^ b;
        5: r[rd] = (sv(a) < sv(b)) ? 8'd1 : 8'd0;
        6: begin s = sv(a) + simm; if (s > 127 || s < -128) m_ovf = 1'b1; r[rt] = 8'(s); end
        7: begin exp_dmem.push_back('{1'b0, addr, 8'h00}); r[rt] = mm[addr]; end
        8: begin exp_dmem.push_back('{1'b1, addr, b}); mm[addr] = b; end
        9:  if (a == b) nxt = 8'(int'(pc) + 1 + simm);
        10: if (a != b) nxt = 8'(int'(pc) + 1 + simm);
        11: nxt = ins[7:0];
        15: begin done = 1; m_halt_pc = pc; nxt = pc; end
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  // Instruction memory responder with configurable wait states.
  initial begin : imem_resp
    int cnt, tgt;
    bit busy;
    busy = 0; cnt = 0; tgt = 0;
    imem_ack = 1'b0; imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!imem_req || rst) begin
        imem_ack = 1'b0; busy = 0;
      end else begin
        if (!busy) begin busy = 1; cnt = 0; tgt = (idly < 0) ? int'($urandom_range(0, 3)) : idly; end
        if (int'(imem_addr) == stall_pc) imem_ack = 1'b0;
        else if (cnt >= tgt) begin imem_ack = 1'b1; imem_rdata = prog[imem_addr]; busy = 0; end
        else begin imem_ack = 1'b0; cnt++; end
      end
    end
  end

  initial begin : dmem_resp
    int cnt, tgt;
    bit busy;
    busy = 0; cnt = 0; tgt = 0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!dmem_req || rst) begin
        dmem_ack = 1'b0; busy = 0;
      end else begin
        if (!busy) begin busy = 1; cnt = 0; tgt = (ddly < 0) ? int'($urandom_range(0, 3)) : ddly; end
        if (cnt >= tgt) begin
          dmem_ack = 1'b1; busy = 0;
          if (dmem_we) dmem[dmem_addr] = dmem_wdata;
          else         dmem_rdata = dmem[dmem_addr];
        end else begin
          dmem_ack = 1'b0; cnt++;
        end
      end
    end
  end

  initial begin : monitor
    fetch_t     f;
    dtxn_t      d;
    logic [7:0] a0, w0;
    logic       we0;
    bit         stable;
    int         cyc;
    cyc = 0; stable = 1; a0 = '0; w0 = '0; we0 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
      end else begin
        if (imem_req && imem_ack) begin
          if (exp_fetch.size() == 0) begin
            n_checks++;
            $display("FAIL fetch_extra: actual fetch at %0h required none", imem_addr);
          end else begin
            f = exp_fetch.pop_front();
            chk("fetch_pc", 32'(imem_addr), 32'(f.pc));
            chk("ovf_at_fetch", 32'(ovf), 32'(f.ov));
          end
        end
        if (dmem_req) begin
          if (cyc == 0) begin a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we; stable = 1; end
          else if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0) stable = 0;
          cyc++;
          if (dmem_ack) begin
            if (exp_dmem.size() == 0) begin
              n_checks++;
              $display("FAIL dmem_extra: actual access at %0h required none", dmem_addr);
            end else begin
              d = exp_dmem.pop_front();
              chk("dmem_we", 32'(dmem_we), 32'(d.we));
              chk("dmem_addr", 32'(dmem_addr), 32'(d.addr));
              if (d.we) chk("dmem_wdata", 32'(dmem_wdata), 32'(d.wdata));
              chk("dmem_stable", 32'(stable), 32'd1);
              if (ddly >= 0) chk("dmem_req_cycles", 32'(cyc), 32'(ddly + 1));
            end
            cyc = 0;
          end
        end else begin
          cyc = 0;
        end
`ifdef RETIRE_TRACE_EN
        if (retire_valid) retire_cnt++;
`endif
      end
    end
  end

  task automatic load_data();
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 8'($urandom);
      mm[i]   = dmem[i];
    end
  endtask

  task automatic run_test(input int max_steps);
    int reqs, i;
    rst = 1'b1;
    load_data();
    model_run(max_steps);
    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_dmem_addr", 32'({dmem_addr, dmem_wdata}), 32'd0);
    chk("rst_flags", 32'({ovf, halted}), 32'd0);
`ifdef RETIRE_TRACE_EN
    chk("rst_retire", 32'(retire_valid), 32'd0);
    retire_cnt = 0;
`endif
    rst = 1'b0;
    i = 0;
    while (i < 5000 && !halted) begin @(negedge clk); i++; end
    chk("halted", 32'(halted), 32'd1);
    reqs = 0;
    repeat (20) begin @(negedge clk); if (imem_req || dmem_req) reqs++; end
    chk("quiet_after_halt", 32'(reqs), 32'd0);
    chk("halt_pc", 32'(imem_addr), 32'(m_halt_pc));
    chk("final_ovf", 32'(ovf), 32'(m_ovf));
    chk("fetch_q_empty", 32'(exp_fetch.size()), 32'd0);
    chk("dmem_q_empty", 32'(exp_dmem.size()), 32'd0);
`ifdef RETIRE_TRACE_EN
    chk("retire_count", 32'(retire_cnt), 32'(m_steps));
`endif
    exp_fetch.delete();
    exp_dmem.delete();
  endtask

  initial begin : main
    int seen, op, imm;
    rst = 1'b0;
    #2;

    clear_prog();
    prog[0] = ei(6, 0, 1, 5); prog[1] = ei(6, 0, 2, 3); prog[2] = er(0, 1, 2, 3);
    prog[3] = ei(8, 0, 3, 0);
    run_test(1000);

    clear_prog();
    prog[0] = ei(6, 0, 1, 8'h7F); prog[1] = ei(6, 1, 1, 1); prog[2] = er(2, 1, 1, 3);
    prog[3] = ei(8, 0, 1, 1);
    run_test(1000);

    ddly = 3;
    clear_prog();
    prog[0] = ei(6, 0, 1, 8'h7F); prog[1] = ei(6, 1, 1, 1); prog[2] = ei(8, 0, 1, 8'h10);
    prog[3] = ei(7, 0, 2, 8'h10); prog[4] = ei(8, 0, 2, 8'h11);
    run_test(1000);
    ddly = 0;

    clear_prog();
    prog[0] = ei(6, 1, 1, 1);  prog[1] = ei(6, 0, 2, 2); prog[2] = ei(9, 1, 2, 3);
    prog[3] = ei(11, 0, 0, 5); prog[4] = ei(11, 0, 0, 8'hFF); prog[5] = ei(9, 0, 0, -2);
    prog[6] = ei(8, 0, 1, 8'h20); prog[255] = ei(12, 0, 0, 0);
    run_test(1000);

    // Withhold the fetch at PC 2, then reset mid-handshake.
    clear_prog();
    prog[0] = ei(6, 0, 1, 8'h55); prog[1] = ei(6, 0, 2, 8'h66);
    stall_pc = 2;
    rst = 1'b1;
    load_data();
    model_run(2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && seen < 5; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 8'd2) seen++;
    end
    chk("stall_reached", 32'(seen), 32'd5);
    chk("stall_fetch_q", 32'(exp_fetch.size()), 32'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_pc", 32'(imem_addr), 32'd0);
    stall_pc = -1;
    exp_fetch.delete();
    clear_prog();
    prog[0] = ei(8, 0, 1, 8'h30); prog[1] = ei(8, 0, 2, 8'h31);
    run_test(1000);

    clear_prog();
    prog[0] = ei(6, 0, 1, 1); prog[1] = ei(6, 0, 2, 2);
    run_test(1000);

    idly = -1; ddly = -1;
    for (int t = 0; t < 6; t++) begin
      clear_prog();
      for (int pc = 0; pc < 24; pc++) begin
        op = int'($urandom_range(0, 14));
        imm = int'($urandom_range(0, 255));
        if (op == 9 || op == 10) imm = int'($urandom_range(0, 3));
        if (op == 11) imm = pc + int'($urandom_range(1, 3));
        prog[pc] = ei(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), imm);
      end
      for (int k = 0; k < 4; k++) prog[24 + k] = ei(8, 0, k, 8'hF0 + k);
      run_test(1000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
